// File: rtl/cpu_axi_pkg.sv
// Shared constants for the CPU-to-AXI3 bridge: ID assignment, fixed AXI fields,
// and the CPU size to AXI size encoding.
package cpu_axi_pkg;

    localparam int unsigned ID_W = 4;

    localparam logic [ID_W-1:0] AXI_ID_INST = 4'd0;
    localparam logic [ID_W-1:0] AXI_ID_DATA = 4'd1;
    localparam logic [ID_W-1:0] AXI_ID_WR   = 4'd1;

    // Single-beat transfers only.
    localparam logic [3:0] AXI_LEN        = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK       = 2'b00;
    localparam logic [3:0] AXI_CACHE      = 4'b0000;
    localparam logic [2:0] AXI_PROT       = 3'b000;

    // CPU size codes 0/1/2 (1/2/4 bytes) map directly onto AXI size.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_os_counter.sv
// Outstanding-transaction counter: counts up on accept, down on response,
// saturating at MAX and at zero.
module axi_os_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inc,
    input  logic                       dec,
    output logic [$clog2(MAX+1)-1:0]   cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign full  = (cnt_q == CW'(MAX));
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU fetch and load/store SRAM-like ports onto one AXI3 master with
// multiple outstanding reads per port and multiple outstanding writes.
module cpu_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_RD_OS = 4,
    parameter int unsigned MAX_WR_OS = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [1:0]          inst_size,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int unsigned RD_CW = $clog2(MAX_RD_OS + 1);
    localparam int unsigned WR_CW = $clog2(MAX_WR_OS + 1);

    logic             ird_full, ird_empty, drd_full, drd_empty, wr_full, wr_empty;
    logic [RD_CW-1:0] ird_cnt, drd_cnt;
    logic [WR_CW-1:0] wr_cnt;

    logic ar_free;
    logic data_rd_ok, data_wr_ok;
    logic inst_acc, data_rd_acc, data_wr_acc;
    logic r_inst, r_data, b_hs;

    // The AR register can take a new request if empty or draining this cycle.
    assign ar_free    = !arvalid || arready;
    // Reads and writes on the data port never overlap, which keeps responses in order.
    assign data_rd_ok = ar_free && !drd_full && wr_empty;
    assign data_wr_ok = !awvalid && !wvalid && !wr_full && drd_empty;

    assign data_addr_ok = data_wr ? data_wr_ok : data_rd_ok;
    assign inst_addr_ok = ar_free && !ird_full && !(data_req && !data_wr && data_rd_ok);

    assign inst_acc    = inst_req && inst_addr_ok;
    assign data_rd_acc = data_req && !data_wr && data_rd_ok;
    assign data_wr_acc = data_req && data_wr && data_wr_ok;

    assign r_inst = rvalid && (rid == AXI_ID_INST);
    assign r_data = rvalid && (rid == AXI_ID_DATA);

    // A data read return takes priority; the write response is held off.
    assign rready = 1'b1;
    assign bready = !r_data;
    assign b_hs   = bvalid && bready;

    assign inst_data_ok = r_inst;
    assign inst_rdata   = rdata;
    assign data_data_ok = r_data || b_hs;
    assign data_rdata   = rdata;

    assign arlen   = AXI_LEN;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;

    assign awid    = AXI_ID_WR;
    assign awlen   = AXI_LEN;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign wid     = AXI_ID_WR;
    assign wlast   = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
        end else if (data_rd_acc) begin
            arvalid <= 1'b1;
            arid    <= AXI_ID_DATA;
            araddr  <= data_addr;
            arsize  <= axi_size(data_size);
        end else if (inst_acc) begin
            arvalid <= 1'b1;
            arid    <= AXI_ID_INST;
            araddr  <= inst_addr;
            arsize  <= axi_size(inst_size);
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (data_wr_acc) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= data_addr;
            awsize  <= axi_size(data_size);
            wdata   <= data_wdata;
            wstrb   <= data_wstrb;
        end else begin
            if (awready) begin
                awvalid <= 1'b0;
            end
            if (wready) begin
                wvalid <= 1'b0;
            end
        end
    end

    axi_os_counter #(.MAX(MAX_RD_OS)) u_inst_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inst_acc),
        .dec   (r_inst),
        .cnt   (ird_cnt),
        .full  (ird_full),
        .empty (ird_empty)
    );

    axi_os_counter #(.MAX(MAX_RD_OS)) u_data_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (data_rd_acc),
        .dec   (r_data),
        .cnt   (drd_cnt),
        .full  (drd_full),
        .empty (drd_empty)
    );

    axi_os_counter #(.MAX(MAX_WR_OS)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (data_wr_acc),
        .dec   (b_hs),
        .cnt   (wr_cnt),
        .full  (wr_full),
        .empty (wr_empty)
    );

    // Response codes and last flags carry no information for single-beat OKAY traffic.
    logic unused_sig;
    assign unused_sig = ^{rresp, rlast, bid, bresp, ird_cnt, drd_cnt, wr_cnt, ird_empty};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Randomized bench for cpu_axi_bridge: a CPU driver and AXI slave model on both sides,
// checked against a transaction-level reference of ordering, data and accept rules.
module tb_cpu_axi_bridge;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned MRD = 4;
    localparam int unsigned MWR = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          inst_req, inst_addr_ok, inst_data_ok;
    logic [AW-1:0] inst_addr;
    logic [1:0]    inst_size;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata, data_rdata;
    logic [3:0]    arid, awid, wid, rid, bid;
    logic [AW-1:0] araddr, awaddr;
    logic [3:0]    arlen, arcache, awlen, awcache;
    logic [2:0]    arsize, arprot, awsize, awprot;
    logic [1:0]    arburst, arlock, awburst, awlock, rresp, bresp;
    logic          arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic [DW-1:0] rdata, wdata;
    logic [3:0]    wstrb;
    logic          wlast, wvalid, wready, bvalid, bready;

    cpu_axi_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_RD_OS(MRD), .MAX_WR_OS(MWR)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference: per-port expected responses in request order.
    logic [31:0] inst_exp[$];
    logic        dq_wr[$];
    logic [31:0] dq_data[$];
    logic [38:0] ar_exp[$];
    logic [34:0] aw_exp[$];
    logic [35:0] w_exp[$];
    logic [31:0] ref_mem[16];
    int          n_ird, n_drd, n_wr;

    // Slave model state.
    logic [31:0] s_mem[16];
    logic [31:0] s_aw[$];
    logic [35:0] s_w[$];
    logic [31:0] s_r0[$], s_r1[$];
    int          b_pend;

    int          mode;      // 0 random traffic, 1 drain, 2 fetch burst with responses withheld
    logic [31:0] inst_seq;

    logic        nx_inst_req, nx_data_req, nx_data_wr, nx_arready, nx_awready, nx_wready;
    logic        nx_rvalid, nx_bvalid;
    logic [1:0]  nx_inst_size, nx_data_size;
    logic [31:0] nx_inst_addr, nx_data_addr, nx_data_wdata, nx_rdata;
    logic [3:0]  nx_data_wstrb, nx_rid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit idle();
        return inst_exp.size() == 0 && dq_wr.size() == 0 && ar_exp.size() == 0 &&
               aw_exp.size() == 0 && w_exp.size() == 0 && s_aw.size() == 0 &&
               s_w.size() == 0 && s_r0.size() == 0 && s_r1.size() == 0 && b_pend == 0 &&
               n_ird == 0 && n_drd == 0 && n_wr == 0 && !inst_req && !data_req;
    endfunction

    task automatic apply();
        inst_req  = nx_inst_req;  inst_addr  = nx_inst_addr;  inst_size  = nx_inst_size;
        data_req  = nx_data_req;  data_wr    = nx_data_wr;    data_size  = nx_data_size;
        data_addr = nx_data_addr; data_wstrb = nx_data_wstrb; data_wdata = nx_data_wdata;
        arready   = nx_arready;   awready    = nx_awready;    wready     = nx_wready;
        rvalid    = nx_rvalid;    rid        = nx_rid;        rdata      = nx_rdata;
        bvalid    = nx_bvalid;
    endtask

    task automatic evaluate();
        bit ar_free, e_drd, e_dwr, e_iok, r_i, r_d, b_hs, w, c0, c1;
        logic [31:0] d, a;
        logic [35:0] ws;
        ar_free = (ar_exp.size() == 0) || arready;
        e_drd   = ar_free && n_drd < MRD && n_wr == 0;
        e_dwr   = aw_exp.size() == 0 && w_exp.size() == 0 && n_wr < MWR && n_drd == 0;
        e_iok   = ar_free && n_ird < MRD && !(data_req && !data_wr && e_drd);
        if (inst_req) check_eq("inst_addr_ok", inst_addr_ok, e_iok);
        if (data_req) check_eq("data_addr_ok", data_addr_ok, data_wr ? e_dwr : e_drd);
        r_i  = rvalid && rid == 4'd0;
        r_d  = rvalid && rid == 4'd1;
        b_hs = bvalid && !r_d;
        check_eq("rready", rready, 1);
        check_eq("bready", bready, !r_d);
        check_eq("inst_data_ok", inst_data_ok, r_i);
        check_eq("data_data_ok", data_data_ok, r_d || b_hs);

        if (r_i) begin
            check_eq("inst_q_depth", inst_exp.size() > 0, 1);
            if (inst_exp.size() > 0) check_eq("inst_rdata", inst_rdata, inst_exp.pop_front());
            n_ird--;
            void'(s_r0.pop_front());
        end
        if (r_d || b_hs) begin
            check_eq("data_q_depth", dq_wr.size() > 0, 1);
            if (dq_wr.size() > 0) begin
                w = dq_wr.pop_front();
                d = dq_data.pop_front();
                check_eq("data_resp_kind", w, b_hs);
                if (r_d) check_eq("data_rdata", data_rdata, d);
            end
            if (r_d) begin n_drd--; void'(s_r1.pop_front()); end
            else begin n_wr--; b_pend--; end
        end

        if (arvalid && arready) begin
            check_eq("ar_q_depth", ar_exp.size() > 0, 1);
            if (ar_exp.size() > 0) check_eq("ar_fields", {araddr, arid, arsize}, ar_exp.pop_front());
            check_eq("ar_fixed", {arlen, arburst, arlock, arcache, arprot},
                     {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            if (arid == 4'd1) s_r1.push_back(s_mem[araddr[5:2]]);
            else s_r0.push_back(inst_fn(araddr));
        end
        if (awvalid && awready) begin
            check_eq("aw_q_depth", aw_exp.size() > 0, 1);
            if (aw_exp.size() > 0) check_eq("aw_fields", {awaddr, awsize}, aw_exp.pop_front());
            check_eq("aw_fixed", {awid, awlen, awburst, awlock, awcache, awprot},
                     {4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
            s_aw.push_back(awaddr);
        end
        if (wvalid && wready) begin
            check_eq("w_q_depth", w_exp.size() > 0, 1);
            if (w_exp.size() > 0) check_eq("w_fields", {wdata, wstrb}, w_exp.pop_front());
            check_eq("w_fixed", {wid, wlast}, {4'd1, 1'b1});
            s_w.push_back({wdata, wstrb});
        end
        if (s_aw.size() > 0 && s_w.size() > 0) begin
            a  = s_aw.pop_front();
            ws = s_w.pop_front();
            s_mem[a[5:2]] = merge(s_mem[a[5:2]], ws[35:4], ws[3:0]);
            b_pend++;
        end

        // Model follows the DUT's accepts so a single fault does not cascade.
        if (data_req && data_addr_ok) begin
            if (data_wr) begin
                ref_mem[data_addr[5:2]] = merge(ref_mem[data_addr[5:2]], data_wdata, data_wstrb);
                dq_wr.push_back(1'b1); dq_data.push_back(32'h0);
                aw_exp.push_back({data_addr, 1'b0, data_size});
                w_exp.push_back({data_wdata, data_wstrb});
                n_wr++;
            end else begin
                dq_wr.push_back(1'b0); dq_data.push_back(ref_mem[data_addr[5:2]]);
                ar_exp.push_back({data_addr, 4'd1, 1'b0, data_size});
                n_drd++;
            end
        end
        if (inst_req && inst_addr_ok) begin
            inst_exp.push_back(inst_fn(inst_addr));
            ar_exp.push_back({inst_addr, 4'd0, 1'b0, inst_size});
            n_ird++;
        end

        if (!inst_req || inst_addr_ok) begin
            nx_inst_req  = (mode == 2) || (mode == 0 && $urandom_range(0, 3) != 0);
            nx_inst_size = 2'd2;
            if (mode == 2) begin nx_inst_addr = inst_seq; inst_seq += 4; end
            else nx_inst_addr = 32'h1000 + ($urandom_range(0, 63) << 2);
        end
        if (!data_req || data_addr_ok) begin
            nx_data_req   = mode == 0 && $urandom_range(0, 2) != 0;
            nx_data_wr    = 1'($urandom_range(0, 1));
            nx_data_size  = 2'($urandom_range(0, 2));
            nx_data_addr  = 32'h2000 + ($urandom_range(0, 15) << 2) +
                            (nx_data_wr ? 0 : $urandom_range(0, 3));
            nx_data_wstrb = 4'($urandom_range(1, 15));
            nx_data_wdata = $urandom;
        end
        nx_arready = (mode == 2) || $urandom_range(0, 3) != 0;
        nx_awready = $urandom_range(0, 2) != 0;
        nx_wready  = $urandom_range(0, 2) != 0;
        c0 = mode != 2 && s_r0.size() > 0 && $urandom_range(0, 2) != 0;
        c1 = mode != 2 && s_r1.size() > 0 && $urandom_range(0, 2) != 0;
        if (c0 && c1) begin
            if ($urandom_range(0, 1) != 0) c0 = 0; else c1 = 0;
        end
        nx_rvalid = c0 || c1;
        nx_rid    = c1 ? 4'd1 : c0 ? 4'd0 : 4'($urandom_range(0, 1));
        nx_rdata  = c1 ? s_r1[0] : c0 ? s_r0[0] : $urandom;
        nx_bvalid = (bvalid && !b_hs) || (b_pend > 0 && $urandom_range(0, 1) != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1 apply();
        @(negedge clk);
        evaluate();
    endtask

    task automatic drain();
        mode = 1;
        for (int i = 0; i < 600 && !idle(); i++) step();
        check_eq("drain_idle", idle(), 1);
    endtask

    initial begin
        rresp = 2'b00; rlast = 1'b1; bid = 4'd1; bresp = 2'b00;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h0101_0101 * i;
            s_mem[i]   = 32'h0101_0101 * i;
        end
        n_ird = 0; n_drd = 0; n_wr = 0; b_pend = 0; mode = 0; inst_seq = 32'h1000;
        nx_inst_req = 0; nx_inst_addr = 0; nx_inst_size = 2;
        nx_data_req = 0; nx_data_wr = 0; nx_data_size = 0; nx_data_addr = 0;
        nx_data_wstrb = 0; nx_data_wdata = 0;
        nx_arready = 0; nx_awready = 0; nx_wready = 0;
        nx_rvalid = 0; nx_rid = 0; nx_rdata = 0; nx_bvalid = 0;
        apply();
        reset = 1'b1;
        #2;
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_rready", rready, 1);
        check_eq("rst_bready", bready, 1);
        check_eq("rst_inst_addr_ok", inst_addr_ok, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (3000) step();
        drain();

        // Fetch burst with responses withheld, then reset with reads in flight.
        mode = 2;
        repeat (5) step();
        check_eq("pre_reset_os", n_ird >= 2, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_arvalid", arvalid, 0);
        check_eq("mid_rst_awvalid", awvalid, 0);
        check_eq("mid_rst_wvalid", wvalid, 0);
        inst_exp.delete(); dq_wr.delete(); dq_data.delete(); ar_exp.delete();
        aw_exp.delete(); w_exp.delete(); s_aw.delete(); s_w.delete();
        s_r0.delete(); s_r1.delete();
        n_ird = 0; n_drd = 0; n_wr = 0; b_pend = 0;
        nx_rvalid = 0; nx_bvalid = 0; nx_data_req = 0;
        nx_inst_req = 1; nx_inst_addr = 32'h1040; nx_arready = 1;
        apply();
        @(posedge clk);
        #1 reset = 1'b0;
        mode = 0;
        @(negedge clk);
        check_eq("post_rst_inst_ok", inst_addr_ok, 1);
        evaluate();
        repeat (400) step();
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
